memory_stage: RTL and testbench

Fourth pipeline stage of the five-stage RV32I core. It consumes the execute stage's outputs (ALU result, store data, control bundle) and performs loads and stores over a request/ready data-memory port, stalling the pipeline while an access is outstanding. It formats load data (byte/half/word, sign/zero extension) and holds the MEM/WB pipeline register that feeds write-back and the WB forwarding path.

---
 rtl/memory_stage_pkg.sv | 26 ++
 rtl/memory_stage_load_formatter.sv | 53 +++++
 rtl/memory_stage.sv | 173 +++++++++++++++++
 tb/tb_memory_stage.sv | 417 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/memory_stage_pkg.sv
// memory_stage_pkg
// Types and constants shared by the MEM stage and its load formatter:
//   mem_state_t   - access FSM states (IDLE, WAIT)
//   F3_*          - funct3 encodings for load/store widths
//   control_type  - pipeline control bundle fields used by the MEM stage
package memory_stage_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    WAIT = 1'b1
  } mem_state_t;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef struct packed {
    logic       reg_write;
    logic       mem_read;
    logic       mem_write;
    logic [2:0] funct3;
  } control_type;

endpackage

// File: rtl/memory_stage_load_formatter.sv
// load_formatter
// Combinational extraction of a byte/half/word from a 32-bit read word,
// followed by sign or zero extension according to funct3.
// Ports:
//   rdata  [31:0] - raw word from data memory
//   addr   [1:0]  - byte offset within the word
//   funct3 [2:0]  - load width / signedness
//   result [31:0] - formatted load value
module load_formatter
  import memory_stage_pkg::*;
(
  input  logic [31:0] rdata,
  input  logic [1:0]  addr,
  input  logic [2:0]  funct3,
  output logic [31:0] result
);

  function automatic logic signed [31:0] sext8(input logic signed [7:0] v);
    return 32'(v);
  endfunction

  function automatic logic signed [31:0] sext16(input logic signed [15:0] v);
    return 32'(v);
  endfunction

  logic [7:0]  lane_b;
  logic [15:0] lane_h;

  always_comb begin
    lane_b = 8'h00;
    lane_h = 16'h0000;
    case (addr)
      2'd0: begin lane_b = rdata[7:0];   lane_h = rdata[15:0];  end
      2'd1: begin lane_b = rdata[15:8];  lane_h = rdata[23:8];  end
      2'd2: begin lane_b = rdata[23:16]; lane_h = rdata[31:16]; end
      // Offset 3 halfword is misaligned and never issued by the core;
      // wrap around so the output is still well defined.
      default: begin lane_b = rdata[31:24]; lane_h = {rdata[7:0], rdata[31:24]}; end
    endcase
  end

  always_comb begin
    result = rdata;
    case (funct3)
      F3_B:    result = sext8(lane_b);
      F3_H:    result = sext16(lane_h);
      F3_BU:   result = {24'h000000, lane_b};
      F3_HU:   result = {16'h0000, lane_h};
      default: result = rdata;
    endcase
  end

endmodule

// File: rtl/memory_stage.sv
// memory_stage
// MEM stage of the five-stage RV32I core: issues loads/stores over a
// request/ready data-memory port, stalls the front of the pipeline while an
// access is outstanding, formats load data and holds the MEM/WB register.
// Ports:
//   clk, reset_n                 - clock, asynchronous active-low reset
//   alu_data_in, memory_data_in  - EX/MEM address/result and store data
//   control_in                   - EX/MEM control bundle
//   mem_forward_data             - combinational MEM-stage forwarding source
//   dmem_req/we/addr/wdata/be    - data-memory request side
//   dmem_ready, dmem_rdata       - data-memory response side
//   stall_out                    - freezes PC, IF/ID, ID/EX, EX/MEM
//   control_out, alu_data_out,
//   load_data_out                - MEM/WB register
//   misaligned_out, bus_error_out- registered one-cycle fault pulses
module memory_stage
  import memory_stage_pkg::*;
#(
  parameter int TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [31:0] alu_data_in,
  input  logic [31:0] memory_data_in,
  input  control_type control_in,
  output logic [31:0] mem_forward_data,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [31:0] dmem_wdata,
  output logic [3:0]  dmem_be,
  input  logic        dmem_ready,
  input  logic [31:0] dmem_rdata,
  output logic        stall_out,
  output control_type control_out,
  output logic [31:0] alu_data_out,
  output logic [31:0] load_data_out,
  output logic        misaligned_out,
  output logic        bus_error_out
);

  localparam int CNT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);

  mem_state_t       state;
  logic [CNT_W-1:0] cnt;

  logic [1:0]  a;
  logic        mem_op;
  logic        misaligned;
  logic        issue;
  logic        at_limit;
  logic        complete;
  logic [31:0] load_fmt;
  control_type squashed;

  control_type ctrl_p1;
  logic [31:0] alu_p1;
  logic [31:0] load_p1;
  logic        misaligned_p1;
  logic        bus_error_p1;

  // ---- stage p0: address decode, request and lane steering (combinational)
  assign a                = alu_data_in[1:0];
  assign mem_forward_data = alu_data_in;
  assign mem_op           = control_in.mem_read | control_in.mem_write;

  always_comb begin
    misaligned = 1'b0;
    if (control_in.funct3[1:0] == 2'b01 && a[0])        misaligned = 1'b1;
    if (control_in.funct3[1:0] == 2'b10 && a != 2'b00)  misaligned = 1'b1;
  end

  assign issue    = mem_op & ~misaligned;
  assign at_limit = (state == WAIT) && (cnt == CNT_W'(TIMEOUT - 1));

  // reset_n gates the request so an in-flight access is abandoned at once.
  assign dmem_req = reset_n & ((state == IDLE) ? issue : 1'b1);
  // Stall drops on the completing cycle so EX/MEM advances with the result;
  // it also drops on the timeout cycle so the faulting access is squashed
  // rather than re-issued.
  assign stall_out = reset_n & ~dmem_ready &
                     ((state == IDLE) ? issue : ~at_limit);
  assign complete  = dmem_req & dmem_ready;

  assign dmem_we   = dmem_req & control_in.mem_write;
  assign dmem_addr = {alu_data_in[31:2], 2'b00};

  always_comb begin
    dmem_be    = 4'b1111;
    dmem_wdata = memory_data_in;
    case (control_in.funct3[1:0])
      2'b00: begin
        dmem_be    = 4'b0001 << a;
        dmem_wdata = {4{memory_data_in[7:0]}};
      end
      2'b01: begin
        dmem_be    = 4'b0011 << a;
        dmem_wdata = {2{memory_data_in[15:0]}};
      end
      default: ;
    endcase
  end

  always_comb begin
    squashed           = control_in;
    squashed.reg_write = 1'b0;
    squashed.mem_read  = 1'b0;
    squashed.mem_write = 1'b0;
  end

  load_formatter u_load_formatter (
    .rdata  (dmem_rdata),
    .addr   (a),
    .funct3 (control_in.funct3),
    .result (load_fmt)
  );

  // ---- stage p1: access FSM and MEM/WB register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state         <= IDLE;
      cnt           <= '0;
      ctrl_p1       <= '0;
      alu_p1        <= '0;
      load_p1       <= '0;
      misaligned_p1 <= 1'b0;
      bus_error_p1  <= 1'b0;
    end else begin
      misaligned_p1 <= 1'b0;
      bus_error_p1  <= 1'b0;
      case (state)
        IDLE: begin
          if (!mem_op || complete) begin
            ctrl_p1 <= control_in;
            alu_p1  <= alu_data_in;
            load_p1 <= load_fmt;
          end else if (misaligned) begin
            ctrl_p1       <= squashed;
            alu_p1        <= alu_data_in;
            misaligned_p1 <= 1'b1;
          end else begin
            ctrl_p1 <= '0;
            cnt     <= '0;
            state   <= WAIT;
          end
        end
        WAIT: begin
          if (dmem_ready) begin
            ctrl_p1 <= control_in;
            alu_p1  <= alu_data_in;
            load_p1 <= load_fmt;
            state   <= IDLE;
          end else if (at_limit) begin
            ctrl_p1      <= '0;
            bus_error_p1 <= 1'b1;
            state        <= IDLE;
          end else begin
            ctrl_p1 <= '0;
            cnt     <= cnt + CNT_W'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign control_out    = ctrl_p1;
  assign alu_data_out   = alu_p1;
  assign load_data_out  = load_p1;
  assign misaligned_out = misaligned_p1;
  assign bus_error_out  = bus_error_p1;

endmodule

// File: tb/tb_memory_stage.sv
// tb_memory_stage
// Scoreboard bench for memory_stage: expected MEM/WB contents are queued when
// an instruction is presented and compared when a non-bubble result appears.
module tb_memory_stage;
  import memory_stage_pkg::*;

  logic        clk;
  logic        reset_n;
  logic [31:0] alu_data_in;
  logic [31:0] memory_data_in;
  control_type control_in;
  logic [31:0] mem_forward_data;
  logic        dmem_req;
  logic        dmem_we;
  logic [31:0] dmem_addr;
  logic [31:0] dmem_wdata;
  logic [3:0]  dmem_be;
  logic        dmem_ready;
  logic [31:0] dmem_rdata;
  logic        stall_out;
  control_type control_out;
  logic [31:0] alu_data_out;
  logic [31:0] load_data_out;
  logic        misaligned_out;
  logic        bus_error_out;

  int errors = 0;
  int checks = 0;

  typedef struct packed {
    control_type c;
    logic [31:0] alu;
    logic [31:0] ld;
    logic        chk_ld;
  } exp_t;

  exp_t sb[$];

  memory_stage #(.TIMEOUT(4)) dut (
    .clk              (clk),
    .reset_n          (reset_n),
    .alu_data_in      (alu_data_in),
    .memory_data_in   (memory_data_in),
    .control_in       (control_in),
    .mem_forward_data (mem_forward_data),
    .dmem_req         (dmem_req),
    .dmem_we          (dmem_we),
    .dmem_addr        (dmem_addr),
    .dmem_wdata       (dmem_wdata),
    .dmem_be          (dmem_be),
    .dmem_ready       (dmem_ready),
    .dmem_rdata       (dmem_rdata),
    .stall_out        (stall_out),
    .control_out      (control_out),
    .alu_data_out     (alu_data_out),
    .load_data_out    (load_data_out),
    .misaligned_out   (misaligned_out),
    .bus_error_out    (bus_error_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic control_type mk(input logic rw, input logic mr,
                                     input logic mw, input logic [2:0] f3);
    control_type c;
    c.reg_write = rw;
    c.mem_read  = mr;
    c.mem_write = mw;
    c.funct3    = f3;
    return c;
  endfunction

  // Reference load formatting, written independently from the RTL lane mux.
  function automatic logic [31:0] fmt_model(input logic [31:0] rd,
                                            input logic [1:0] off,
                                            input logic [2:0] f3);
    logic [31:0] sh;
    sh = rd >> {off, 3'b000};
    case (f3)
      3'b000:  return {{24{sh[7]}}, sh[7:0]};
      3'b001:  return {{16{sh[15]}}, sh[15:0]};
      3'b100:  return {24'h0, sh[7:0]};
      3'b101:  return {16'h0, sh[15:0]};
      default: return rd;
    endcase
  endfunction

  function automatic exp_t mk_exp(input control_type c, input logic [31:0] addr,
                                  input logic [31:0] rd);
    exp_t e;
    e.c      = c;
    e.alu    = addr;
    e.ld     = fmt_model(rd, addr[1:0], c.funct3);
    e.chk_ld = 1'b1;
    return e;
  endfunction

  // Scoreboard monitor: every non-bubble MEM/WB value must match the queue head.
  always @(posedge clk) begin
    #1;
    if (reset_n && control_out != '0) begin
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL sb_unexpected: got ctrl=%h alu=%h, expected no result", control_out, alu_data_out);
      end else begin
        exp_t e;
        e = sb.pop_front();
        if (control_out !== e.c || alu_data_out !== e.alu ||
            (e.chk_ld && load_data_out !== e.ld)) begin
          errors++;
          $display("FAIL sb_result: got ctrl=%h alu=%h ld=%h, expected ctrl=%h alu=%h ld=%h",
                   control_out, alu_data_out, load_data_out, e.c, e.alu, e.ld);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    control_in     = '0;
    alu_data_in    = '0;
    memory_data_in = '0;
    dmem_ready     = 1'b0;
    dmem_rdata     = '0;
  endtask

  // Presents one instruction; memory answers after `waits` not-ready cycles.
  task automatic issue(input control_type c, input logic [31:0] addr,
                       input logic [31:0] wd, input logic [31:0] rd,
                       input int waits, output int stalls,
                       output logic [3:0] be, output logic [31:0] wdat,
                       output int reqs);
    control_in     = c;
    alu_data_in    = addr;
    memory_data_in = wd;
    dmem_rdata     = rd;
    stalls = 0;
    reqs   = 0;
    be     = '0;
    wdat   = '0;
    for (int i = 0; i <= waits; i++) begin
      dmem_ready = (i == waits);
      #1;
      if (i == 0) begin
        be   = dmem_be;
        wdat = dmem_wdata;
      end
      stalls += int'(stall_out);
      reqs   += int'(dmem_req);
      tick();
    end
    idle_inputs();
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    control_in     = mk(1, 1, 0, F3_W);
    alu_data_in    = 32'h100;
    memory_data_in = '0;
    dmem_ready     = 1'b0;
    dmem_rdata     = '0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (dmem_req !== 1'b0 || stall_out !== 1'b0) begin
      errors++; $display("FAIL reset_req: got req=%b stall=%b, expected 0/0", dmem_req, stall_out);
    end
    checks++;
    if (control_out !== '0 || alu_data_out !== '0 || load_data_out !== '0 ||
        misaligned_out !== 1'b0 || bus_error_out !== 1'b0) begin
      errors++; $display("FAIL reset_regs: got ctrl=%h alu=%h ld=%h mis=%b be=%b, expected all 0",
                         control_out, alu_data_out, load_data_out, misaligned_out, bus_error_out);
    end
    idle_inputs();
    reset_n = 1'b1;
    tick();
  endtask

  task automatic test_sw_zero_wait();
    int s, r; logic [3:0] be; logic [31:0] wd;
    control_type c;
    c = mk(0, 0, 1, F3_W);
    control_in = c; alu_data_in = 32'h100; memory_data_in = 32'hDEADBEEF; dmem_ready = 1'b1;
    #1;
    checks++;
    if (dmem_req !== 1'b1 || dmem_we !== 1'b1 || dmem_addr !== 32'h100) begin
      errors++; $display("FAIL sw_req: got req=%b we=%b addr=%h, expected 1/1/00000100", dmem_req, dmem_we, dmem_addr);
    end
    checks++;
    if (mem_forward_data !== 32'h100) begin
      errors++; $display("FAIL fwd_data: got %h, expected 00000100", mem_forward_data);
    end
    sb.push_back(mk_exp(c, 32'h100, 32'h0));
    issue(c, 32'h100, 32'hDEADBEEF, 32'h0, 0, s, be, wd, r);
    checks++;
    if (be !== 4'b1111 || wd !== 32'hDEADBEEF || s !== 0) begin
      errors++; $display("FAIL sw_lanes: got be=%b wdata=%h stalls=%0d, expected 1111/deadbeef/0", be, wd, s);
    end
  endtask

  task automatic test_load_byte();
    int s, r; logic [3:0] be; logic [31:0] wd;
    control_type c;
    c = mk(1, 1, 0, F3_B);
    sb.push_back(mk_exp(c, 32'h103, 32'h80112233));
    issue(c, 32'h103, 32'h0, 32'h80112233, 3, s, be, wd, r);
    checks++;
    if (s !== 3 || r !== 4) begin
      errors++; $display("FAIL lb_stall: got stalls=%0d reqs=%0d, expected 3/4", s, r);
    end
    checks++;
    if (load_data_out !== 32'hFFFFFF80) begin
      errors++; $display("FAIL lb_data: got %h, expected ffffff80", load_data_out);
    end
    c = mk(1, 1, 0, F3_BU);
    sb.push_back(mk_exp(c, 32'h103, 32'h80112233));
    issue(c, 32'h103, 32'h0, 32'h80112233, 1, s, be, wd, r);
    checks++;
    if (s !== 1 || load_data_out !== 32'h00000080) begin
      errors++; $display("FAIL lbu_data: got stalls=%0d ld=%h, expected 1/00000080", s, load_data_out);
    end
  endtask

  task automatic test_half();
    int s, r; logic [3:0] be; logic [31:0] wd;
    control_type c;
    c = mk(0, 0, 1, F3_H);
    sb.push_back(mk_exp(c, 32'h102, 32'h0));
    issue(c, 32'h102, 32'h0000ABCD, 32'h0, 2, s, be, wd, r);
    checks++;
    if (be !== 4'b1100 || wd !== 32'hABCDABCD || s !== 2) begin
      errors++; $display("FAIL sh_lanes: got be=%b wdata=%h stalls=%0d, expected 1100/abcdabcd/2", be, wd, s);
    end
    c = mk(0, 0, 1, F3_B);
    sb.push_back(mk_exp(c, 32'h101, 32'h0));
    issue(c, 32'h101, 32'h000000A5, 32'h0, 0, s, be, wd, r);
    checks++;
    if (be !== 4'b0010 || wd !== 32'hA5A5A5A5) begin
      errors++; $display("FAIL sb_lanes: got be=%b wdata=%h, expected 0010/a5a5a5a5", be, wd);
    end
    c = mk(1, 1, 0, F3_HU);
    sb.push_back(mk_exp(c, 32'h102, 32'hABCD0000));
    issue(c, 32'h102, 32'h0, 32'hABCD0000, 0, s, be, wd, r);
    checks++;
    if (load_data_out !== 32'h0000ABCD || s !== 0) begin
      errors++; $display("FAIL lhu_data: got ld=%h stalls=%0d, expected 0000abcd/0", load_data_out, s);
    end
  endtask

  task automatic test_misaligned();
    control_type c, q;
    c = mk(1, 1, 0, F3_W);
    q = mk(0, 0, 0, F3_W);
    sb.push_back('{c: q, alu: 32'h101, ld: 32'h0, chk_ld: 1'b0});
    control_in = c; alu_data_in = 32'h101; dmem_ready = 1'b1;
    #1;
    checks++;
    if (dmem_req !== 1'b0 || stall_out !== 1'b0) begin
      errors++; $display("FAIL mis_req: got req=%b stall=%b, expected 0/0", dmem_req, stall_out);
    end
    tick();
    idle_inputs();
    checks++;
    if (misaligned_out !== 1'b1 || control_out.reg_write !== 1'b0) begin
      errors++; $display("FAIL mis_pulse: got mis=%b rw=%b, expected 1/0", misaligned_out, control_out.reg_write);
    end
    tick();
    checks++;
    if (misaligned_out !== 1'b0) begin
      errors++; $display("FAIL mis_once: got %b, expected 0", misaligned_out);
    end
    control_in = mk(0, 0, 1, F3_H); alu_data_in = 32'h103;
    #1;
    checks++;
    if (dmem_req !== 1'b0) begin
      errors++; $display("FAIL mis_sh_req: got %b, expected 0", dmem_req);
    end
    idle_inputs();
    tick();
  endtask

  task automatic test_timeout();
    int s, r;
    control_in = mk(1, 1, 0, F3_W); alu_data_in = 32'h200; dmem_ready = 1'b0;
    s = 0; r = 0;
    for (int i = 0; i < 5; i++) begin
      #1;
      if (i < 4) s += int'(stall_out);
      r += int'(dmem_req);
      if (i < 4 && bus_error_out !== 1'b0) begin
        checks++; errors++;
        $display("FAIL to_early: bus_error=%b at cycle %0d, expected 0", bus_error_out, i);
      end
      tick();
    end
    checks++;
    if (s !== 4 || r !== 5) begin
      errors++; $display("FAIL to_wait: got stalls=%0d reqs=%0d, expected 4/5", s, r);
    end
    checks++;
    if (bus_error_out !== 1'b1 || control_out !== '0) begin
      errors++; $display("FAIL to_pulse: got berr=%b ctrl=%h, expected 1/00", bus_error_out, control_out);
    end
    idle_inputs();
    #1;
    checks++;
    if (dmem_req !== 1'b0 || stall_out !== 1'b0) begin
      errors++; $display("FAIL to_idle: got req=%b stall=%b, expected 0/0", dmem_req, stall_out);
    end
    tick();
    checks++;
    if (bus_error_out !== 1'b0) begin
      errors++; $display("FAIL to_once: got %b, expected 0", bus_error_out);
    end
  endtask

  task automatic test_ready_at_limit();
    int s, r; logic [3:0] be; logic [31:0] wd;
    control_type c;
    c = mk(1, 1, 0, F3_W);
    sb.push_back(mk_exp(c, 32'h500, 32'hCAFEF00D));
    issue(c, 32'h500, 32'h0, 32'hCAFEF00D, 4, s, be, wd, r);
    checks++;
    if (s !== 4 || bus_error_out !== 1'b0 || load_data_out !== 32'hCAFEF00D) begin
      errors++; $display("FAIL ready_wins: got stalls=%0d berr=%b ld=%h, expected 4/0/cafef00d",
                         s, bus_error_out, load_data_out);
    end
  endtask

  task automatic test_back_to_back();
    int s, r; logic [3:0] be; logic [31:0] wd;
    control_type c;
    c = mk(1, 0, 0, F3_B);
    sb.push_back(mk_exp(c, 32'h1234, 32'h000000FF));
    issue(c, 32'h1234, 32'h0, 32'h000000FF, 0, s, be, wd, r);
    checks++;
    if (r !== 0 || s !== 0) begin
      errors++; $display("FAIL pass_req: got reqs=%0d stalls=%0d, expected 0/0", r, s);
    end
    c = mk(1, 1, 0, F3_W);
    sb.push_back(mk_exp(c, 32'h400, 32'h11223344));
    issue(c, 32'h400, 32'h0, 32'h11223344, 0, s, be, wd, r);
    c = mk(1, 1, 0, F3_H);
    sb.push_back(mk_exp(c, 32'h402, 32'h80001234));
    issue(c, 32'h402, 32'h0, 32'h80001234, 0, s, be, wd, r);
    checks++;
    if (load_data_out !== 32'hFFFF8000) begin
      errors++; $display("FAIL lh_data: got %h, expected ffff8000", load_data_out);
    end
    c = mk(1, 1, 0, F3_BU);
    sb.push_back(mk_exp(c, 32'h401, 32'h0000AB00));
    issue(c, 32'h401, 32'h0, 32'h0000AB00, 0, s, be, wd, r);
  endtask

  task automatic test_reset_mid_wait();
    control_in = mk(1, 1, 0, F3_W); alu_data_in = 32'h300; dmem_ready = 1'b0;
    tick();
    #1;
    checks++;
    if (dmem_req !== 1'b1 || stall_out !== 1'b1) begin
      errors++; $display("FAIL rw_wait: got req=%b stall=%b, expected 1/1", dmem_req, stall_out);
    end
    reset_n = 1'b0;
    #1;
    checks++;
    if (dmem_req !== 1'b0 || stall_out !== 1'b0) begin
      errors++; $display("FAIL rw_drop: got req=%b stall=%b, expected 0/0", dmem_req, stall_out);
    end
    checks++;
    if (control_out !== '0 || alu_data_out !== '0 || load_data_out !== '0 ||
        misaligned_out !== 1'b0 || bus_error_out !== 1'b0) begin
      errors++; $display("FAIL rw_regs: got ctrl=%h alu=%h ld=%h, expected all 0",
                         control_out, alu_data_out, load_data_out);
    end
    tick();
    idle_inputs();
    reset_n = 1'b1;
    tick();
    #1;
    checks++;
    if (dmem_req !== 1'b0 || stall_out !== 1'b0) begin
      errors++; $display("FAIL rw_after: got req=%b stall=%b, expected 0/0", dmem_req, stall_out);
    end
  endtask

  initial begin
    test_reset();
    test_sw_zero_wait();
    test_load_byte();
    test_half();
    test_misaligned();
    test_timeout();
    test_ready_at_limit();
    test_back_to_back();
    test_reset_mid_wait();
    tick();
    checks++;
    if (sb.size() != 0) begin
      errors++; $display("FAIL sb_drain: %0d results outstanding, expected 0", sb.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
